dump_sequencer: RTL and testbench
=================================

Name: dump_sequencer

Overview:
- Parametrised channel-dump controller for the capture path.
- On a host dump command it:
  - reads the selected channel's gain and offset calibration words from EEPROM over SPI;
  - streams a programmable number of RAM samples out through the UART response path, starting at the current address.
- Generalises the fixed 3-channel, full-buffer dump to NUM_CH channels, a programmable length, and host abort.

Parameters:
- NUM_CH, 4: number of capture channels; CH_W = $clog2(NUM_CH), minimum 1.
- ADDR_W, 9: RAM address width.
- GAIN_W, 3: AFE gain code width per channel.
- SPI_W, 16: EEPROM command width; must satisfy SPI_W >= 9+GAIN_W+CH_W (elaboration-time assertion).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start_dump  in  1  one-cycle dump request
- abort  in  1  one-cycle host abort
- channel  in  CH_W  channel to dump
- ch_gain  in  NUM_CH*GAIN_W  packed AFE gain codes; channel i at [i*GAIN_W +: GAIN_W]
- dump_len  in  ADDR_W  samples to send; 0 means 2^ADDR_W
- spi_rdy  in  1  SPI master idle/done
- uart_rdy  in  1  UART transmitter ready
- start_spi  out  1  one-cycle SPI kick
- spi_tx_data  out  SPI_W  EEPROM command
- flop_gain  out  1  capture gain word from SPI rx
- flop_offset  out  1  capture offset word from SPI rx
- inc_addr  out  1  increment RAM address counter
- start_uart  out  1  one-cycle UART response kick
- ch_sel  out  CH_W  registered channel, routed to RAM mux
- busy  out  1  high in every state except IDLE
- dump_done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort-acknowledge pulse

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
  - Reset values: state IDLE, ch_sel 0, sample counter 0, length register 0.
  - All pulse outputs 0; spi_tx_data 0.
- Pulse outputs are Mealy decodes of state and inputs, high for exactly one cycle per event.
- spi_tx_data fields:
  - [7:0] = 0.
  - [8] = op: 1 = gain read, 0 = offset/junk.
  - [9 +: GAIN_W] = gain of ch_sel.
  - [9+GAIN_W +: CH_W] = ch_sel.
  - Remaining bits 0.
  - Outside command states spi_tx_data = 0.
- States and transitions:
  - IDLE: on start_dump, capture ch_sel <= channel and len <= dump_len, clear the counter, go to RD_GAIN. A channel >= NUM_CH is clamped to 0.
  - RD_GAIN: start_spi with op=1; go to RD_OFF.
  - RD_OFF: wait for spi_rdy; on ready, start_spi with op=0 and go to RD_JUNK.
  - RD_JUNK: wait for spi_rdy; on ready, flop_gain and start_spi with op=0; go to EE_WAIT.
  - EE_WAIT: wait for spi_rdy; on ready, flop_offset and go to SEND.
  - SEND: wait for uart_rdy; on ready, start_uart and go to INC.
  - INC: inc_addr, counter++, go to CHECK.
  - CHECK:
    - If counter == len (len 0 treated as 2^ADDR_W, i.e. counter wrapped to 0 after at least one sample), go to DRAIN.
    - Otherwise go to SEND.
  - DRAIN: wait for uart_rdy; then dump_done and go to IDLE.
- Sample counter:
  - Width ADDR_W+1, so a full-buffer dump counts to 2^ADDR_W without aliasing.
  - Address wrap-around is the address counter's responsibility; this block only pulses inc_addr.
- Latency:
  - start_dump to first start_spi: 1 cycle.
  - Last start_uart to dump_done: >= 2 cycles.
- Abort:
  - abort in any non-IDLE state returns to IDLE next cycle with an aborted pulse; no further start_spi, start_uart or inc_addr.
  - If abort and another event coincide, abort wins and the event's pulse is suppressed.
  - abort in IDLE is ignored.
- start_dump while busy is ignored.
- Reset mid-dump returns to IDLE silently, with no dump_done or aborted.

Optional Feature:
- DUMP_TRAILER_EN defined:
  - After the final sample, CHECK goes to TRAILER, which waits for uart_rdy, then pulses start_uart with output uart_trailer=1 before DRAIN.
  - Host sees len+1 responses.
  - uart_trailer is a port only when the macro is defined.
- DUMP_TRAILER_EN undefined: no TRAILER state, no uart_trailer port; exactly len responses.

Decomposition:
- Shared package dump_pkg:
  - state enum dump_state_t;
  - SPI op constants OP_GAIN=1'b1, OP_OFFSET=1'b0;
  - field offset localparams;
  - function building spi_tx_data from (ch, gain, op).
- One natural sub-module, dump_len_counter: counter with clear/inc, len capture and terminal-count compare, including len==0 as 2^ADDR_W.

Test Plan:
- Basic dump: ch=2, gains {3'd1,3'd5,3'd7,3'd2}, dump_len=4, spi_rdy/uart_rdy held high.
  - Commands 0x2F00 (op=1), 0x2E00, 0x2E00.
  - One flop_gain, one flop_offset, 4 start_uart, 4 inc_addr, one dump_done.
- Full wrap: dump_len=0, ADDR_W=9 → exactly 512 start_uart/inc_addr pulses, then dump_done.
- Back-pressure: uart_rdy low for 10 cycles before sample 2 → no start_uart or inc_addr during the stall; sample count unchanged at 3 for dump_len=3.
- Abort in SEND after 2 samples → aborted pulse the next cycle, busy low, no dump_done; a new start_dump then restarts cleanly.
- Ignored/clamped inputs:
  - start_dump while busy → no re-capture of ch_sel.
  - channel=5 with NUM_CH=6 passes through; channel=3 with NUM_CH=3 clamps to ch_sel=0.
- rst_n asserted mid-EE_WAIT → all outputs at reset values immediately; no pulses after release.
- With DUMP_TRAILER_EN defined: dump_len=2 → 3 start_uart pulses, uart_trailer high only on the third.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and helpers for the channel-dump sequencer.
// Optional build macro: DUMP_TRAILER_EN adds the TRAILER state.
package dump_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_GAIN,
    ST_RD_OFF,
    ST_RD_JUNK,
    ST_EE_WAIT,
    ST_SEND,
    ST_INC,
    ST_CHECK,
`ifdef DUMP_TRAILER_EN
    ST_TRAILER,
`endif
    ST_DRAIN
  } dump_state_t;

  // EEPROM command opcodes carried in the op bit
  localparam logic OP_GAIN   = 1'b1;
  localparam logic OP_OFFSET = 1'b0;

  // EEPROM command field positions; the low byte is always zero
  localparam int OP_BIT   = 8;
  localparam int GAIN_LSB = 9;

  // Builds an EEPROM command word: {zeros, ch, gain, op, 8'h00}.
  // Returned wide; the caller truncates to its SPI word width.
  function automatic logic [63:0] build_spi_cmd(
    input logic [31:0] ch,
    input logic [31:0] gain,
    input logic        op,
    input int          gain_w,
    input int          ch_w
  );
    logic [63:0] gain_mask;
    logic [63:0] ch_mask;
    logic [63:0] cmd;
    gain_mask   = (64'd1 << gain_w) - 64'd1;
    ch_mask     = (64'd1 << ch_w) - 64'd1;
    cmd         = '0;
    cmd[OP_BIT] = op;
    cmd         = cmd | ((64'(gain) & gain_mask) << GAIN_LSB);
    cmd         = cmd | ((64'(ch) & ch_mask) << (GAIN_LSB + gain_w));
    return cmd;
  endfunction

endpackage

// File: rtl/dump_len_counter.sv
// Sample counter with length capture and terminal-count compare.
// A captured length of 0 means a full buffer of 2^ADDR_W samples; the
// counter is one bit wider than the address so that case never aliases.
module dump_len_counter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_inc,
  output logic              o_term
);

  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W:0]   w_target;

  // Capture length and clear on load, otherwise count sent samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_len   <= i_len;
    end else if (i_inc) begin
      r_count <= r_count + (ADDR_W+1)'(1);
    end
  end

  // Terminal value: zero length stands for the full 2^ADDR_W samples
  always_comb begin
    w_target = {1'b0, r_len};
    if (r_len == '0) begin
      w_target = {1'b1, {ADDR_W{1'b0}}};
    end
  end

  assign o_term = (r_count == w_target);

endmodule

// File: rtl/dump_sequencer.sv
// Channel-dump controller: reads gain/offset calibration for one channel
// from EEPROM over SPI, then streams dump_len RAM samples to the UART.
// Optional build macro: DUMP_TRAILER_EN appends one trailer response
// (flagged on o_uart_trailer) after the final sample.
module dump_sequencer
  import dump_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 9,
  parameter  int GAIN_W = 3,
  parameter  int SPI_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start_dump,
  input  logic                     i_abort,
  input  logic [CH_W-1:0]          i_channel,
  input  logic [NUM_CH*GAIN_W-1:0] i_ch_gain,
  input  logic [ADDR_W-1:0]        i_dump_len,
  input  logic                     i_spi_rdy,
  input  logic                     i_uart_rdy,
  output logic                     o_start_spi,
  output logic [SPI_W-1:0]         o_spi_tx_data,
  output logic                     o_flop_gain,
  output logic                     o_flop_offset,
  output logic                     o_inc_addr,
  output logic                     o_start_uart,
  output logic [CH_W-1:0]          o_ch_sel,
  output logic                     o_busy,
  output logic                     o_dump_done,
  output logic                     o_aborted
`ifdef DUMP_TRAILER_EN
  ,output logic                    o_uart_trailer
`endif
);

  // The command word must hold the low byte, op bit, gain and channel
  if (SPI_W < GAIN_LSB + GAIN_W + CH_W) begin : g_spi_w_check
    $error("dump_sequencer: SPI_W too narrow for gain and channel fields");
  end

  dump_state_t       r_state;
  dump_state_t       w_state_next;
  logic [CH_W-1:0]   r_ch_sel;
  logic [CH_W-1:0]   w_ch_clamped;
  logic [GAIN_W-1:0] w_gain [NUM_CH];
  logic [GAIN_W-1:0] w_gain_sel;
  logic              w_load;
  logic              w_term;
  logic              w_cmd_valid;
  logic              w_op;

  // Unpack the per-channel gain codes
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gain
    assign w_gain[gi] = i_ch_gain[gi*GAIN_W +: GAIN_W];
  end

  assign w_gain_sel   = w_gain[r_ch_sel];
  assign w_ch_clamped = (32'(i_channel) < NUM_CH) ? i_channel : '0;
  assign o_ch_sel     = r_ch_sel;
  assign o_busy       = (r_state != ST_IDLE);

  dump_len_counter #(
    .ADDR_W (ADDR_W)
  ) u_len_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_len  (i_dump_len),
    .i_inc  (o_inc_addr),
    .o_term (w_term)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Channel captured at dump start, held for the whole dump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_sel <= '0;
    end else if (w_load) begin
      r_ch_sel <= w_ch_clamped;
    end
  end

  // Next-state and Mealy pulse decode; abort overrides every other event
  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_cmd_valid   = 1'b0;
    w_op          = OP_OFFSET;
    o_start_spi   = 1'b0;
    o_flop_gain   = 1'b0;
    o_flop_offset = 1'b0;
    o_inc_addr    = 1'b0;
    o_start_uart  = 1'b0;
    o_dump_done   = 1'b0;
    o_aborted     = 1'b0;
`ifdef DUMP_TRAILER_EN
    o_uart_trailer = 1'b0;
`endif

    // Command word follows the state so it is stable around each kick
    case (r_state)
      ST_RD_GAIN: begin
        w_cmd_valid = 1'b1;
        w_op        = OP_GAIN;
      end
      ST_RD_OFF, ST_RD_JUNK: begin
        w_cmd_valid = 1'b1;
      end
      default: ;
    endcase

    if (r_state != ST_IDLE && i_abort) begin
      w_state_next = ST_IDLE;
      o_aborted    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start_dump) begin
            w_load       = 1'b1;
            w_state_next = ST_RD_GAIN;
          end
        end
        ST_RD_GAIN: begin
          o_start_spi  = 1'b1;
          w_state_next = ST_RD_OFF;
        end
        ST_RD_OFF: begin
          if (i_spi_rdy) begin
            o_start_spi  = 1'b1;
            w_state_next = ST_RD_JUNK;
          end
        end
        ST_RD_JUNK: begin
          // Gain word is back; the junk read clocks out the offset
          if (i_spi_rdy) begin
            o_flop_gain  = 1'b1;
            o_start_spi  = 1'b1;
            w_state_next = ST_EE_WAIT;
          end
        end
        ST_EE_WAIT: begin
          if (i_spi_rdy) begin
            o_flop_offset = 1'b1;
            w_state_next  = ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_uart_rdy) begin
            o_start_uart = 1'b1;
            w_state_next = ST_INC;
          end
        end
        ST_INC: begin
          o_inc_addr   = 1'b1;
          w_state_next = ST_CHECK;
        end
        ST_CHECK: begin
          if (w_term) begin
`ifdef DUMP_TRAILER_EN
            w_state_next = ST_TRAILER;
`else
            w_state_next = ST_DRAIN;
`endif
          end else begin
            w_state_next = ST_SEND;
          end
        end
`ifdef DUMP_TRAILER_EN
        ST_TRAILER: begin
          if (i_uart_rdy) begin
            o_start_uart   = 1'b1;
            o_uart_trailer = 1'b1;
            w_state_next   = ST_DRAIN;
          end
        end
`endif
        ST_DRAIN: begin
          if (i_uart_rdy) begin
            o_dump_done  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign o_spi_tx_data = w_cmd_valid
                       ? SPI_W'(build_spi_cmd(32'(r_ch_sel), 32'(w_gain_sel), w_op, GAIN_W, CH_W))
                       : '0;

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: directed scenarios plus
// randomized dumps with random SPI/UART ready patterns, checked against
// a transaction-level expectation (command words, pulse counts, latency).
module tb_dump_sequencer;

  localparam int NUM_CH = 6;
  localparam int ADDR_W = 9;
  localparam int GAIN_W = 3;
  localparam int SPI_W  = 16;
  localparam int CH_W   = 3;
`ifdef DUMP_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start_dump, abort;
  logic [CH_W-1:0]          channel;
  logic [NUM_CH*GAIN_W-1:0] ch_gain;
  logic [ADDR_W-1:0]        dump_len;
  logic                     spi_rdy, uart_rdy;
  logic                     start_spi, flop_gain, flop_offset, inc_addr;
  logic                     start_uart, busy, dump_done, aborted;
  logic [SPI_W-1:0]         spi_tx_data;
  logic [CH_W-1:0]          ch_sel;
  logic                     uart_trailer;

  always #5 clk = ~clk;

  dump_sequencer #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .GAIN_W (GAIN_W),
    .SPI_W  (SPI_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start_dump  (start_dump),
    .i_abort       (abort),
    .i_channel     (channel),
    .i_ch_gain     (ch_gain),
    .i_dump_len    (dump_len),
    .i_spi_rdy     (spi_rdy),
    .i_uart_rdy    (uart_rdy),
    .o_start_spi   (start_spi),
    .o_spi_tx_data (spi_tx_data),
    .o_flop_gain   (flop_gain),
    .o_flop_offset (flop_offset),
    .o_inc_addr    (inc_addr),
    .o_start_uart  (start_uart),
    .o_ch_sel      (ch_sel),
    .o_busy        (busy),
    .o_dump_done   (dump_done),
    .o_aborted     (aborted)
`ifdef DUMP_TRAILER_EN
    ,.o_uart_trailer (uart_trailer)
`endif
  );
`ifndef DUMP_TRAILER_EN
  assign uart_trailer = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int gains [NUM_CH];
  bit rnd_rdy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected EEPROM command from the field layout
  function automatic int exp_cmd(input int ch, input int gain, input int op);
    return (ch << (9 + GAIN_W)) | (gain << 9) | (op << 8);
  endfunction

  // ---------------- event monitor (samples on the falling edge) ----------
  logic [SPI_W-1:0] spi_q [$];
  int cyc = 0, n_uart = 0, n_inc = 0, n_fg = 0, n_fo = 0, n_done = 0;
  int n_abt = 0, n_trl = 0, n_viol = 0, spi_since = 0;
  int cyc_start = 0, cyc_first_spi = 0, cyc_last_uart = 0, cyc_done = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && start_dump && !busy) begin
      cyc_start <= cyc;
      spi_since <= 0;
    end
    if (start_spi) begin
      spi_q.push_back(spi_tx_data);
      if (spi_since == 0) cyc_first_spi <= cyc;
      spi_since <= spi_since + 1;
    end
    if (start_uart) begin
      n_uart        <= n_uart + 1;
      cyc_last_uart <= cyc;
    end
    if (inc_addr)     n_inc <= n_inc + 1;
    if (flop_gain)    n_fg  <= n_fg + 1;
    if (flop_offset)  n_fo  <= n_fo + 1;
    if (aborted)      n_abt <= n_abt + 1;
    if (uart_trailer) n_trl <= n_trl + 1;
    if (dump_done) begin
      n_done   <= n_done + 1;
      cyc_done <= cyc;
    end
    n_viol <= n_viol
            + int'(start_uart && !uart_rdy)
            + int'(!busy && (start_spi || flop_gain || flop_offset || inc_addr ||
                             start_uart || dump_done || aborted))
            + int'(flop_gain && !start_spi)
            + int'(dump_done && aborted)
            + int'(uart_trailer && !start_uart);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      spi_rdy  = ($urandom_range(0, 3) != 0);
      uart_rdy = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic pack_gains();
    for (int i = 0; i < NUM_CH; i++) ch_gain[i*GAIN_W +: GAIN_W] = GAIN_W'(gains[i]);
  endtask

  // mode: 0 plain, 1 random readies, 2 start_dump poked while busy,
  //       3 UART stall before the second sample
  task automatic run_dump(input int ch, input int len, input int mode);
    int b_uart, b_inc, b_fg, b_fo, b_done, b_abt, b_trl, b_viol, b_spi;
    int ch_eff, gain, n_exp, k, s_uart, s_inc;
    bit stalled;
    b_uart = n_uart; b_inc = n_inc; b_fg = n_fg; b_fo = n_fo; b_done = n_done;
    b_abt = n_abt; b_trl = n_trl; b_viol = n_viol; b_spi = spi_q.size();
    ch_eff = (ch < NUM_CH) ? ch : 0;
    gain   = gains[ch_eff];
    n_exp  = (len == 0) ? (1 << ADDR_W) : len;
    pack_gains();
    spi_rdy = 1'b1; uart_rdy = 1'b1; rnd_rdy = (mode == 1);
    channel = CH_W'(ch); dump_len = ADDR_W'(len);
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    k = 0; stalled = 1'b0;
    while (n_done == b_done && k < 5000) begin
      if (mode == 2 && k == 5) begin
        channel    = CH_W'((ch_eff + 1) % NUM_CH);
        start_dump = 1'b1;
      end
      if (mode == 3 && !stalled && (n_uart - b_uart) == 1) begin
        uart_rdy = 1'b0;
        step(); step();
        s_uart = n_uart; s_inc = n_inc;
        repeat (8) step();
        check_eq("stall_uart", n_uart, s_uart);
        check_eq("stall_inc", n_inc, s_inc);
        uart_rdy = 1'b1; stalled = 1'b1;
      end
      step();
      start_dump = 1'b0;
      k++;
    end
    rnd_rdy = 1'b0; spi_rdy = 1'b1; uart_rdy = 1'b1;
    step();
    check_eq("done_cnt", n_done - b_done, 1);
    check_eq("uart_cnt", n_uart - b_uart, n_exp + TRL);
    check_eq("inc_cnt", n_inc - b_inc, n_exp);
    check_eq("flop_gain_cnt", n_fg - b_fg, 1);
    check_eq("flop_off_cnt", n_fo - b_fo, 1);
    check_eq("trailer_cnt", n_trl - b_trl, TRL);
    check_eq("abort_cnt", n_abt - b_abt, 0);
    check_eq("ch_sel", 32'(ch_sel), ch_eff);
    check_eq("busy_after", 32'(busy), 0);
    check_eq("protocol_viol", n_viol - b_viol, 0);
    check_eq("spi_latency", cyc_first_spi - cyc_start, 1);
    check_eq("tail_latency_ok", 32'((cyc_done - cyc_last_uart) >= (2 - TRL)), 1);
    check_eq("spi_cnt", spi_q.size() - b_spi, 3);
    if (spi_q.size() - b_spi >= 3) begin
      check_eq("cmd_gain", 32'(spi_q[b_spi]), exp_cmd(ch_eff, gain, 1));
      check_eq("cmd_off", 32'(spi_q[b_spi+1]), exp_cmd(ch_eff, gain, 0));
      check_eq("cmd_junk", 32'(spi_q[b_spi+2]), exp_cmd(ch_eff, gain, 0));
    end
    $display("dump ch=%0d len=%0d mode=%0d responses=%0d cycles=%0d",
             ch, len, mode, n_uart - b_uart, k);
  endtask

  task automatic run_abort();
    int b_uart, b_inc, b_done, b_abt, b_viol, k;
    b_uart = n_uart; b_inc = n_inc; b_done = n_done; b_abt = n_abt; b_viol = n_viol;
    pack_gains();
    spi_rdy = 1'b1; uart_rdy = 1'b1; channel = 3'd1; dump_len = 9'd8;
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    k = 0;
    while ((n_uart - b_uart) < 2 && k < 200) begin
      step();
      k++;
    end
    uart_rdy = 1'b0;
    step(); step();
    // Now parked in SEND; abort coincides with a ready UART
    abort = 1'b1; uart_rdy = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 0);
    repeat (5) step();
    check_eq("abort_pulse", n_abt - b_abt, 1);
    check_eq("abort_uart", n_uart - b_uart, 2);
    check_eq("abort_inc", n_inc - b_inc, 2);
    check_eq("abort_no_done", n_done - b_done, 0);
    check_eq("abort_viol", n_viol - b_viol, 0);
    $display("abort after %0d samples, aborted=%0d", n_uart - b_uart, n_abt - b_abt);
  endtask

  task automatic run_reset_mid();
    int b_fg, b_tot, k;
    b_fg = n_fg;
    pack_gains();
    spi_rdy = 1'b1; uart_rdy = 1'b1; channel = 3'd3; dump_len = 9'd5;
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    k = 0;
    while (n_fg == b_fg && k < 100) begin
      step();
      k++;
    end
    spi_rdy = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ch_sel", 32'(ch_sel), 0);
    check_eq("rst_spi_data", 32'(spi_tx_data), 0);
    check_eq("rst_pulses", 32'({start_spi, flop_gain, flop_offset, inc_addr,
                                start_uart, dump_done, aborted}), 0);
    b_tot = n_uart + n_inc + n_fg + n_fo + n_done + n_abt + spi_q.size();
    repeat (3) step();
    rst_n = 1'b1; spi_rdy = 1'b1;
    repeat (20) step();
    check_eq("post_rst_quiet",
             n_uart + n_inc + n_fg + n_fo + n_done + n_abt + spi_q.size(), b_tot);
    check_eq("post_rst_busy", 32'(busy), 0);
    $display("reset mid EE_WAIT, events after release=%0d",
             n_uart + n_inc + n_fg + n_fo + n_done + n_abt + spi_q.size() - b_tot);
  endtask

  initial begin
    int b_abt;
    rst_n = 1'b0; start_dump = 1'b0; abort = 1'b0; channel = '0;
    ch_gain = '0; dump_len = '0; spi_rdy = 1'b1; uart_rdy = 1'b1;
    #2;
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_ch_sel", 32'(ch_sel), 0);
    check_eq("reset_spi_data", 32'(spi_tx_data), 0);
    check_eq("reset_pulses", 32'({start_spi, flop_gain, flop_offset, inc_addr,
                                  start_uart, dump_done, aborted}), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Basic: channel 2 gain 7 gives commands 0x2F00 / 0x2E00 / 0x2E00
    gains = '{2, 5, 7, 1, 4, 6};
    run_dump(2, 4, 0);
    check_eq("basic_cmd0", 32'(spi_q[0]), 32'h2F00);
    check_eq("basic_cmd1", 32'(spi_q[1]), 32'h2E00);
    check_eq("basic_cmd2", 32'(spi_q[2]), 32'h2E00);

    run_dump(1, 0, 0);   // full-buffer dump
    run_dump(4, 3, 3);   // UART back-pressure
    run_abort();
    run_dump(0, 2, 0);   // clean restart after abort
    run_dump(3, 6, 2);   // start_dump ignored while busy
    run_dump(5, 2, 0);   // highest valid channel
    run_dump(6, 2, 0);   // out of range -> channel 0
    run_dump(7, 1, 0);

    // Abort while idle is ignored
    b_abt = n_abt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check_eq("idle_abort_busy", 32'(busy), 0);
    check_eq("idle_abort_pulse", n_abt - b_abt, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NUM_CH; i++) gains[i] = $urandom_range(0, 7);
      run_dump($urandom_range(0, 7), $urandom_range(1, 24), 1);
    end

    run_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
